// File: rtl/mem_line_responder.sv
// Line-granular backing memory behind a one-outstanding memreq/memresp
// val/rdy interface. Responses appear a fixed p_latency cycles after the
// request is accepted.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | ready for a request; a write/init lands in the array on accept
// S_WAIT | latency countdown, nothing presented on either interface
// S_RESP | response presented from latched fields until memresp_rdy
module mem_line_responder #(
  parameter int p_num_lines = 64,
  parameter int p_latency   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  input  logic [2:0]   memreq_type,
  input  logic [7:0]   memreq_opaque,
  input  logic [31:0]  memreq_addr,
  input  logic [3:0]   memreq_len,
  input  logic [127:0] memreq_data,
  output logic         memresp_val,
  input  logic         memresp_rdy,
  output logic [2:0]   memresp_type,
  output logic [7:0]   memresp_opaque,
  output logic [1:0]   memresp_test,
  output logic [3:0]   memresp_len,
  output logic [127:0] memresp_data
);

  localparam int         IW       = $clog2(p_num_lines);
  localparam logic [3:0] LAT_INIT = 4'(p_latency - 1);

  localparam logic [2:0] T_WRITE = 3'd1;
  localparam logic [2:0] T_INIT  = 3'd2;
  localparam logic [3:0] L_WORD  = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2:0]      type_q, type_d;
  logic [7:0]      opaque_q, opaque_d;
  logic [3:0]      len_q, len_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [1:0]      word_q, word_d;

  logic [127:0]    mem_q [p_num_lines];
  logic            mem_we;
  logic [127:0]    mem_line_d;
  logic [IW-1:0]   req_idx;
  logic [127:0]    rd_line;
  logic [127:0]    rd_word;
  logic            resp_is_wr;

  // Address bits outside the line index and word offset never matter.
  logic            unused_addr;
  assign unused_addr = ^{memreq_addr[31:4+IW], memreq_addr[1:0]};

  assign req_idx      = memreq_addr[4+IW-1:4];
  assign memresp_test = 2'b00;

  // Word writes merge into the currently stored line.
  always_comb begin
    mem_line_d = memreq_data;
    if (memreq_len == L_WORD) begin
      mem_line_d = mem_q[req_idx];
      mem_line_d[{memreq_addr[3:2], 5'd0} +: 32] = memreq_data[31:0];
    end
  end

  always_comb begin
    rd_line    = mem_q[idx_q];
    rd_word    = {96'd0, rd_line[{word_q, 5'd0} +: 32]};
    resp_is_wr = (type_q == T_WRITE) || (type_q == T_INIT);
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    type_d         = type_q;
    opaque_d       = opaque_q;
    len_d          = len_q;
    idx_d          = idx_q;
    word_d         = word_q;
    mem_we         = 1'b0;
    memreq_rdy     = 1'b0;
    memresp_val    = 1'b0;
    memresp_type   = 3'd0;
    memresp_opaque = 8'd0;
    memresp_len    = 4'd0;
    memresp_data   = 128'd0;

    case (state_q)
      S_IDLE: begin
        memreq_rdy = 1'b1;
        if (memreq_val) begin
          type_d   = memreq_type;
          opaque_d = memreq_opaque;
          len_d    = memreq_len;
          idx_d    = req_idx;
          word_d   = memreq_addr[3:2];
          mem_we   = (memreq_type == T_WRITE) || (memreq_type == T_INIT);
          if (p_latency == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_INIT;
          end
        end
      end

      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_RESP: begin
        memresp_val    = 1'b1;
        memresp_type   = type_q;
        memresp_opaque = opaque_q;
        memresp_len    = len_q;
        // Illegal types fall through to read data so the requester never stalls.
        if (!resp_is_wr) begin
          memresp_data = (len_q == L_WORD) ? rd_word : rd_line;
        end
        if (memresp_rdy) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      type_q   <= 3'd0;
      opaque_q <= 8'd0;
      len_q    <= 4'd0;
      idx_q    <= '0;
      word_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      opaque_q <= opaque_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < p_num_lines; i++) begin
        mem_q[i] <= 128'd0;
      end
    end else if (mem_we) begin
      mem_q[req_idx] <= mem_line_d;
    end
  end

  a_legal_req : assert property (@(posedge clk) disable iff (reset)
    (memreq_val && memreq_rdy) |->
      (((memreq_len == 4'd0) || (memreq_len == L_WORD)) && (memreq_type < 3'd3)));

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench: instance A (latency 2) and instance B (latency 0), with
// directed requests pushing hand-computed responses for a negedge monitor.
`timescale 1ns/1ps
module tb_mem_line_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]   typ;
    logic [7:0]   opq;
    logic [3:0]   len;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit   seen0 = 1'b0;
  bit   seen1 = 1'b0;

  logic         rst_a, a_req_val, a_req_rdy, a_resp_val, a_resp_rdy;
  logic [2:0]   a_req_type, a_resp_type;
  logic [7:0]   a_req_opaque, a_resp_opaque;
  logic [31:0]  a_req_addr;
  logic [3:0]   a_req_len, a_resp_len;
  logic [127:0] a_req_data, a_resp_data;
  logic [1:0]   a_resp_test;

  logic         rst_b, b_req_val, b_req_rdy, b_resp_val, b_resp_rdy;
  logic [2:0]   b_req_type, b_resp_type;
  logic [7:0]   b_req_opaque, b_resp_opaque;
  logic [31:0]  b_req_addr;
  logic [3:0]   b_req_len, b_resp_len;
  logic [127:0] b_req_data, b_resp_data;
  logic [1:0]   b_resp_test;

  mem_line_responder #(.p_num_lines(64), .p_latency(2)) u_dut_a (
    .clk(clk), .reset(rst_a),
    .memreq_val(a_req_val), .memreq_rdy(a_req_rdy), .memreq_type(a_req_type),
    .memreq_opaque(a_req_opaque), .memreq_addr(a_req_addr), .memreq_len(a_req_len),
    .memreq_data(a_req_data),
    .memresp_val(a_resp_val), .memresp_rdy(a_resp_rdy), .memresp_type(a_resp_type),
    .memresp_opaque(a_resp_opaque), .memresp_test(a_resp_test), .memresp_len(a_resp_len),
    .memresp_data(a_resp_data)
  );

  mem_line_responder #(.p_num_lines(64), .p_latency(0)) u_dut_b (
    .clk(clk), .reset(rst_b),
    .memreq_val(b_req_val), .memreq_rdy(b_req_rdy), .memreq_type(b_req_type),
    .memreq_opaque(b_req_opaque), .memreq_addr(b_req_addr), .memreq_len(b_req_len),
    .memreq_data(b_req_data),
    .memresp_val(b_resp_val), .memresp_rdy(b_resp_rdy), .memresp_type(b_resp_type),
    .memresp_opaque(b_resp_opaque), .memresp_test(b_resp_test), .memresp_len(b_resp_len),
    .memresp_data(b_resp_data)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic mon(input int d, input logic rst, input logic val, input logic rdy,
                     input logic req_rdy, input logic [2:0] t, input logic [7:0] o,
                     input logic [1:0] ts, input logic [3:0] l, input logic [127:0] dat);
    exp_t  e;
    bit    have;
    bit    seen;
    string p;
    p = (d == 0) ? "a" : "b";
    if (rst) begin
      if (d == 0) seen0 = 1'b0; else seen1 = 1'b0;
      return;
    end
    check({p, "_rdy_excl"}, 128'(val && req_rdy), 128'd0);
    if (!val) return;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (!have) begin
      check({p, "_unexpected_resp"}, 128'(val), 128'd0);
      return;
    end
    e    = (d == 0) ? q0[0] : q1[0];
    seen = (d == 0) ? seen0 : seen1;
    if (!seen) check({p, "_latency"}, 128'(cyc), 128'(e.cyc));
    check({p, "_type"},   128'(t),  128'(e.typ));
    check({p, "_opaque"}, 128'(o),  128'(e.opq));
    check({p, "_test"},   128'(ts), 128'd0);
    check({p, "_len"},    128'(l),  128'(e.len));
    check({p, "_data"},   dat,      e.data);
    seen = !rdy;
    if (rdy) begin
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (d == 0) seen0 = seen; else seen1 = seen;
  endtask

  always @(negedge clk) begin
    mon(0, rst_a, a_resp_val, a_resp_rdy, a_req_rdy, a_resp_type, a_resp_opaque,
        a_resp_test, a_resp_len, a_resp_data);
    mon(1, rst_b, b_resp_val, b_resp_rdy, b_req_rdy, b_resp_type, b_resp_opaque,
        b_resp_test, b_resp_len, b_resp_data);
  end

  // Starts and ends at posedge+1; 'hold' leaves memreq_val high afterwards.
  task automatic send(input int d, input logic [2:0] t, input logic [7:0] o,
                      input logic [31:0] a, input logic [3:0] l, input logic [127:0] wd,
                      input logic [127:0] ed, input bit want, input bit hold, output int acc);
    exp_t e;
    bit   ok;
    ok  = 1'b0;
    acc = -1;
    if (d == 0) begin
      a_req_val = 1'b1; a_req_type = t; a_req_opaque = o;
      a_req_addr = a; a_req_len = l; a_req_data = wd;
    end else begin
      b_req_val = 1'b1; b_req_type = t; b_req_opaque = o;
      b_req_addr = a; b_req_len = l; b_req_data = wd;
    end
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((d == 0) ? a_req_rdy : b_req_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 128'(ok), 128'd1);
    if (ok) begin
      acc = cyc + 1;
      if (want) begin
        e.typ  = t;
        e.opq  = o;
        e.len  = l;
        e.data = ed;
        e.cyc  = acc + ((d == 0) ? 2 : 0);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    @(posedge clk); #1;
    if (!hold) begin
      if (d == 0) a_req_val = 1'b0; else b_req_val = 1'b0;
    end
  endtask

  task automatic drain(input int d);
    for (int n = 0; n < 200; n++) begin
      if (((d == 0) ? q0.size() : q1.size()) == 0) break;
      @(posedge clk); #1;
    end
    check("drain_timeout", 128'((d == 0) ? q0.size() : q1.size()), 128'd0);
  endtask

  localparam logic [127:0] D2 = 128'h0123456789ABCDEF_0123456789ABCDEF;
  localparam logic [127:0] D3 = 128'h01234567_DEADBEEF_01234567_89ABCDEF;
  localparam logic [127:0] DA = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
  localparam logic [127:0] DX = 128'hCAFEF00D_11223344_55667788_99AABBCC;
  localparam logic [127:0] L3 = 128'h00000000_00000000_00001234_00000000;

  int acc, acc1, acc2, acc3;
  bit got;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_req_val = 1'b0; a_req_type = 3'd0; a_req_opaque = 8'd0; a_req_addr = 32'd0;
    a_req_len = 4'd0; a_req_data = 128'd0; a_resp_rdy = 1'b1;
    b_req_val = 1'b0; b_req_type = 3'd0; b_req_opaque = 8'd0; b_req_addr = 32'd0;
    b_req_len = 4'd0; b_req_data = 128'd0; b_resp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    @(negedge clk);
    check("rst_a_req_rdy",   128'(a_req_rdy),     128'd1);
    check("rst_a_resp_val",  128'(a_resp_val),    128'd0);
    check("rst_a_resp_type", 128'(a_resp_type),   128'd0);
    check("rst_a_resp_opq",  128'(a_resp_opaque), 128'd0);
    check("rst_a_resp_len",  128'(a_resp_len),    128'd0);
    check("rst_a_resp_data", a_resp_data,         128'd0);
    check("rst_b_req_rdy",   128'(b_req_rdy),     128'd1);
    check("rst_b_resp_val",  128'(b_resp_val),    128'd0);
    @(posedge clk); #1;

    // Cold read; write line / readback; word merge and word read.
    send(0, 3'd0, 8'h11, 32'h0000_0100, 4'd0, 128'd0, 128'd0, 1, 0, acc); drain(0);
    send(0, 3'd1, 8'h21, 32'h0000_1000, 4'd0, D2, 128'd0, 1, 0, acc);     drain(0);
    send(0, 3'd0, 8'h22, 32'h0000_1000, 4'd0, 128'd0, D2, 1, 0, acc);     drain(0);
    send(0, 3'd1, 8'h31, 32'h0000_1008, 4'd4,
         {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'hDEADBEEF}, 128'd0, 1, 0, acc); drain(0);
    send(0, 3'd0, 8'h32, 32'h0000_1000, 4'd0, 128'd0, D3, 1, 0, acc);     drain(0);
    send(0, 3'd0, 8'h33, 32'h0000_1008, 4'd4, 128'd0,
         {96'd0, 32'hDEADBEEF}, 1, 0, acc);                                drain(0);

    // Stalled response; low address bits ignored on a line read.
    a_resp_rdy = 1'b0;
    send(0, 3'd0, 8'h41, 32'h0000_1004, 4'd0, 128'd0, D3, 1, 0, acc);
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (a_resp_val) begin
        got = 1'b1;
        break;
      end
    end
    check("stall_resp_seen", 128'(got), 128'd1);
    repeat (4) begin
      @(negedge clk);
      check("stall_req_rdy", 128'(a_req_rdy),  128'd0);
      check("stall_val",     128'(a_resp_val), 128'd1);
    end
    @(posedge clk); #1;
    a_resp_rdy = 1'b1;
    drain(0);
    @(negedge clk);
    check("post_stall_val", 128'(a_resp_val), 128'd0);
    @(posedge clk); #1;

    // Aliasing modulo 64 lines * 16 bytes.
    send(0, 3'd1, 8'h61, 32'h0000_0000, 4'd0, DA, 128'd0, 1, 0, acc); drain(0);
    send(0, 3'd0, 8'h62, 32'h0000_0400, 4'd0, 128'd0, DA, 1, 0, acc); drain(0);

    // Reset while counting down: response dropped and array cleared.
    send(0, 3'd0, 8'h63, 32'h0000_0000, 4'd0, 128'd0, 128'd0, 0, 0, acc);
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rst_drop_val", 128'(a_resp_val), 128'd0);
    end
    check("rst_drop_req_rdy", 128'(a_req_rdy), 128'd1);
    @(posedge clk); #1;
    send(0, 3'd0, 8'h64, 32'h0000_0000, 4'd0, 128'd0, 128'd0, 1, 0, acc); drain(0);
    send(0, 3'd0, 8'h65, 32'h0000_1000, 4'd0, 128'd0, 128'd0, 1, 0, acc); drain(0);

    // Latency 0: set up lines, then back-to-back reads with val held high.
    send(1, 3'd2, 8'h50, 32'h0000_0020, 4'd0, DX, 128'd0, 1, 0, acc); drain(1);
    send(1, 3'd1, 8'h5F, 32'h0000_0034, 4'd4,
         {96'hAAAAAAAA_AAAAAAAA_AAAAAAAA, 32'h00001234}, 128'd0, 1, 0, acc); drain(1);
    send(1, 3'd0, 8'h51, 32'h0000_0020, 4'd0, 128'd0, DX, 1, 1, acc1);
    send(1, 3'd0, 8'h52, 32'h0000_0034, 4'd4, 128'd0, {96'd0, 32'h00001234}, 1, 1, acc2);
    send(1, 3'd0, 8'h53, 32'h0000_0030, 4'd0, 128'd0, L3, 1, 0, acc3);
    drain(1);
    check("b2b_spacing_1", 128'(acc2 - acc1), 128'd2);
    check("b2b_spacing_2", 128'(acc3 - acc2), 128'd2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
